// File: rtl/orpheus_pkg.sv
// Shared constants and types for the orpheus phase/sine blocks.
// Angles use sine16 units: a quarter turn is 0x2000, a full turn 0x8000.
package orpheus_pkg;

  localparam int          SINE_FULL_SCALE = 4096;
  localparam logic [15:0] QUARTER_TURN    = 16'h2000;
  localparam int          ASIN_SAR_BITS   = 13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } asin_state_t;

  // Odd Taylor series of sin(pi/2 * x), x in [0,1]; coefficients in Q24.
  localparam logic signed [63:0] SIN_C1 = 64'sd26353589;
  localparam logic signed [63:0] SIN_C3 = 64'sd10837479;
  localparam logic signed [63:0] SIN_C5 = 64'sd1337020;
  localparam logic signed [63:0] SIN_C7 = 64'sd78547;
  localparam logic signed [63:0] SIN_C9 = 64'sd2692;

endpackage

// File: rtl/orpheus_sine16.sv
// Combinational sine evaluator: 16-bit angle (quarter turn 0x2000) to Q12 sine.
// The angle is folded onto the first quadrant and fed to a Horner polynomial.
module orpheus_sine16
  import orpheus_pkg::*;
(
  input  logic        [15:0] i_angle,
  output logic signed [15:0] o_sine
);

  logic        [1:0]  quadrant;
  logic        [12:0] offset;
  logic        [13:0] fold;
  logic signed [63:0] x;
  logic signed [63:0] x2;
  logic signed [63:0] p7;
  logic signed [63:0] p5;
  logic signed [63:0] p3;
  logic signed [63:0] p1;
  logic signed [63:0] prod;
  logic        [12:0] mag;
  logic               unused_bits;

  always_comb begin
    quadrant = i_angle[14:13];
    offset   = i_angle[12:0];
    // Odd quadrants run backwards from the quarter-turn peak.
    fold     = quadrant[0] ? (14'h2000 - {1'b0, offset}) : {1'b0, offset};
    x        = {50'd0, fold};
    x2       = x * x;
    p7       = -SIN_C7 + ((SIN_C9 * x2) >>> 26);
    p5       =  SIN_C5 + ((p7 * x2) >>> 26);
    p3       = -SIN_C3 + ((p5 * x2) >>> 26);
    p1       =  SIN_C1 + ((p3 * x2) >>> 26);
    // Q24 * Q13 -> Q37; round to nearest Q12.
    prod     = (p1 * x + (64'sd1 <<< 24)) >>> 25;
    mag      = prod[12:0];
    o_sine   = quadrant[1] ? -$signed({3'b000, mag}) : $signed({3'b000, mag});
  end

  assign unused_bits = ^{i_angle[15], prod[63:13]};

endmodule

// File: rtl/orpheus_asin16.sv
// Arcsine by successive approximation over one sine16 evaluator.
// 13 SEARCH cycles resolve the angle bit by bit from 0x1000 down to 0x0001.
module orpheus_asin16
  import orpheus_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic signed [15:0] i_sample,
  input  logic               i_sample_valid,
  output logic               o_sample_ready,
  output logic signed [15:0] o_angle,
  output logic               o_angle_valid,
  input  logic               i_angle_ready,
  output asin_state_t        o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; the producer holds data stable until then, and ready never
  // depends combinationally on valid.

  localparam logic [3:0]  BIT_TOP   = 4'(ASIN_SAR_BITS - 1);
  localparam logic [16:0] MAG_FULL  = 17'(SINE_FULL_SCALE);

  asin_state_t        state_q;
  asin_state_t        state_d;
  logic               sign_q;
  logic        [15:0] mag_q;
  logic        [12:0] acc_q;
  logic        [3:0]  bit_idx_q;
  logic signed [15:0] angle_q;

  logic               in_fire;
  logic        [16:0] in_mag;
  logic               in_saturate;
  logic               in_zero;
  logic        [12:0] trial;
  logic signed [15:0] sine_val;
  logic        [15:0] sine_mag;
  logic               keep;
  logic        [12:0] acc_next;
  logic               last_bit;

  always_comb begin
    in_fire     = i_sample_valid && (state_q == IDLE);
    // 17-bit magnitude so that -32768 does not wrap.
    in_mag      = i_sample[15] ? (17'd0 - {i_sample[15], i_sample}) : {1'b0, i_sample};
    in_saturate = (in_mag >= MAG_FULL);
    in_zero     = (in_mag == 17'd0);
    trial       = acc_q | (13'd1 << bit_idx_q);
    sine_mag    = sine_val[15] ? 16'(-sine_val) : sine_val;
    keep        = (sine_mag <= mag_q);
    acc_next    = keep ? trial : acc_q;
    last_bit    = (bit_idx_q == 4'd0);
  end

  orpheus_sine16 u_sine (
    .i_angle ({3'b000, trial}),
    .o_sine  (sine_val)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          state_d = (in_saturate || in_zero) ? DONE : SEARCH;
        end
      end
      SEARCH: begin
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_angle_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_sample_ready = (state_q == IDLE);
    o_angle_valid  = (state_q == DONE);
    o_dbg_state    = state_q;
  end

  assign o_angle = angle_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sign_q    <= 1'b0;
      mag_q     <= 16'd0;
      acc_q     <= 13'd0;
      bit_idx_q <= BIT_TOP;
      angle_q   <= 16'sd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            sign_q    <= i_sample[15];
            mag_q     <= in_mag[15:0];
            acc_q     <= 13'd0;
            bit_idx_q <= BIT_TOP;
            if (in_saturate) begin
              angle_q <= i_sample[15] ? -QUARTER_TURN : QUARTER_TURN;
            end else if (in_zero) begin
              angle_q <= 16'sd0;
            end
          end
        end
        SEARCH: begin
          acc_q     <= acc_next;
          bit_idx_q <= last_bit ? BIT_TOP : (bit_idx_q - 4'd1);
          if (last_bit) begin
            angle_q <= sign_q ? -$signed({3'b000, acc_next}) : $signed({3'b000, acc_next});
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_orpheus_asin16.sv
// Scoreboard bench for orpheus_asin16 against a real-valued sine table.
module tb_orpheus_asin16;
  import orpheus_pkg::*;

  // clock / reset
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] sample = 16'sd0;
  logic               sample_valid = 1'b0;
  logic               sample_ready;
  logic signed [15:0] angle;
  logic               angle_valid;
  logic               angle_ready = 1'b0;
  asin_state_t        dbg_state;

  always #5 clk = ~clk;

  orpheus_asin16 dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sample       (sample),
    .i_sample_valid (sample_valid),
    .o_sample_ready (sample_ready),
    .o_angle        (angle),
    .o_angle_valid  (angle_valid),
    .i_angle_ready  (angle_ready),
    .o_dbg_state    (dbg_state)
  );

  // scoreboard
  logic [15:0] exp_q[$];
  int          tol_q[$];
  int          lat_q[$];
  int          sin_tab[0:8192];
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    n_vec++;
    if ((got - exp > tol) || (exp - got > tol)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int model_asin(input int s);
    int m;
    int best;
    m = (s < 0) ? -s : s;
    if (m >= 4096) return (s < 0) ? -8192 : 8192;
    best = 0;
    for (int b = 8192; b >= 0; b--) begin
      if (sin_tab[b] <= m) begin
        best = b;
        break;
      end
    end
    return (s < 0) ? -best : best;
  endfunction

  // driver: one transaction, optional hold in DONE before accepting
  task automatic run_sample(input int s, input int tol, input string tag,
                            input int hold, output int obs);
    int  lat;
    bit  seen;
    int  m;
    int  exp_a;
    int  first;
    m = (s < 0) ? -s : s;
    exp_q.push_back(16'(model_asin(s)));
    tol_q.push_back(tol);
    lat_q.push_back((m >= 4096 || m == 0) ? 1 : 14);
    @(negedge clk);
    check({tag, "_rdy"}, int'(sample_ready), 1);
    sample       = 16'(s);
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      sample       = 16'($urandom);
      sample_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
      if (angle_valid) seen = 1'b1;
    end
    check({tag, "_lat"}, lat, lat_q.pop_front());
    exp_a = int'($signed(exp_q.pop_front()));
    obs   = int'(angle);
    check({tag, "_ang"}, obs, exp_a, tol_q.pop_front());
    first = obs;
    for (int h = 0; h < hold; h++) begin
      sample       = 16'($urandom);
      sample_valid = 1'b1;
      @(negedge clk);
      check({tag, "_hold_ang"}, int'(angle), first);
      check({tag, "_hold_vld"}, int'(angle_valid), 1);
      check({tag, "_hold_rdy"}, int'(sample_ready), 0);
    end
    angle_ready = 1'b1;
    @(posedge clk);
    #1;
    angle_ready  = 1'b0;
    sample_valid = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, int'(dbg_state), int'(IDLE));
    check({tag, "_vld_off"}, int'(angle_valid), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  obs;
    int  ok;
    bit  seen;
    int  r;

    for (int i = 0; i <= 8192; i++) begin
      sin_tab[i] = int'($floor(4096.0 * $sin(real'(i) * 3.14159265358979 / 16384.0) + 0.5));
    end

    // reset values
    #12;
    check("rst_vld", int'(angle_valid), 0);
    check("rst_ang", int'(angle), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", int'(sample_ready), 1);

    // saturate and zero paths
    run_sample(4096, 0, "pos_full", 0, obs);
    check("pos_full_hex", obs, 16'h2000);
    run_sample(-4096, 0, "neg_full", 0, obs);
    check("neg_full_hex", obs & 32'hFFFF, 32'hE000);
    run_sample(-32768, 0, "min_int", 0, obs);
    check("min_int_hex", obs & 32'hFFFF, 32'hE000);
    run_sample(0, 0, "zero", 0, obs);

    // 45 degrees, both signs; negative case also exercises hold in DONE
    run_sample(2896, 1, "sin45", 0, obs);
    run_sample(-2896, 1, "nsin45", 5, obs);

    // sweep of the quarter wave
    for (int a = 0; a <= 8192; a += 64) begin
      run_sample(sin_tab[a], 2, "sweep", 0, obs);
      if (obs < 0) obs = 0;
      if (obs > 8192) obs = 8192;
      ok = (sin_tab[obs] <= sin_tab[a] + 1) &&
           ((obs == 8192) || (sin_tab[a] < sin_tab[obs + 1] + 1)) ? 1 : 0;
      check("sweep_prop", ok, 1);
    end

    // random magnitudes, both signs
    for (int k = 0; k < 12; k++) begin
      r = $urandom_range(0, 9000) - 4500;
      run_sample(r, 2, "rand", 0, obs);
    end

    // reset during SEARCH discards the pending result
    exp_q.push_back(16'(model_asin(2896)));
    @(negedge clk);
    sample       = 16'sd2896;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("mid_state", int'(dbg_state), int'(SEARCH));
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", int'(angle_valid), 0);
    check("mid_rst_ang", int'(angle), 0);
    check("mid_rst_state", int'(dbg_state), int'(IDLE));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (angle_valid) seen = 1'b1;
    end
    check("mid_rst_no_pulse", int'(seen), 0);
    check("mid_rst_rdy", int'(sample_ready), 1);
    run_sample(2048, 1, "post_rst", 0, obs);
    check("post_rst_hex", obs, 16'h0AAB, 1);

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/orpheus_asin16.md
ORPHEUS_ASIN16 -- requirements
Module: orpheus_asin16

Interface
REQ-001 The block SHALL use one clock, i_clk, with all state updated on its rising edge.
REQ-002 The block SHALL use reset i_rst_n, asynchronous and active-low.
REQ-003 Port list (name  direction  width  meaning):
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_sample  in  16 signed  sine-domain value, Q12 (full scale +/-4096)
- i_sample_valid  in  1  i_sample present
- o_sample_ready  out  1  block can accept a sample
- o_angle  out  16 signed  phase in sine16 angle units (quarter turn = 0x2000)
- o_angle_valid  out  1  o_angle holds a result
- i_angle_ready  in  1  downstream accepts o_angle

Function
REQ-004 Operation SHALL be the inverse of orpheus_sine16 over [-quarter, +quarter]: o_angle = largest a in [0, 0x2000] with sine16(a) <= |i_sample|, negated when i_sample < 0.
REQ-005 An input handshake SHALL occur on a rising edge with i_sample_valid && o_sample_ready; i_sample is captured on that edge.
REQ-006 States: IDLE, SEARCH, DONE.
- IDLE: o_sample_ready = 1.
- SEARCH: o_sample_ready = 0.
- DONE: o_sample_ready = 0, o_angle_valid = 1.
REQ-007 The captured sample's magnitude SHALL be computed in 17 bits, so that -32768 is handled without overflow; the sign SHALL be stored separately.
REQ-008 IDLE transitions on an input handshake:
- magnitude >= 4096: go to DONE with o_angle = +/-0x2000.
- magnitude == 0: go to DONE with o_angle = 0x0000.
- Otherwise: go to SEARCH with accumulator = 0 and bit index = 12.
REQ-009 Each SEARCH cycle SHALL form trial = accumulator | (1 << bit index) and keep the bit iff sine16(trial) <= magnitude, then decrement the bit index.
REQ-010 After the bit-0 cycle (13 SEARCH cycles total), the FSM SHALL go to DONE with o_angle = sign ? -accumulator : accumulator.
REQ-011 Latency from the input-handshake edge to o_angle_valid high SHALL be:
- 14 cycles on the search path.
- 1 cycle on the saturate and zero paths.
REQ-012 In DONE, o_angle and o_angle_valid SHALL hold stable until i_angle_ready = 1 on a rising edge, which returns the FSM to IDLE.
REQ-013 o_sample_ready SHALL NOT be asserted in the cycle of output acceptance, so there is no same-cycle passthrough.
REQ-014 Changes to i_sample_valid or i_sample outside IDLE SHALL have no effect on the result.
REQ-015 sine16 comparisons SHALL use the unsigned magnitude of the evaluator output; evaluator non-monotonicity SHALL NOT alter the rule of REQ-009.

Reset
REQ-016 On i_rst_n = 0, the block SHALL immediately set:
- state = IDLE
- o_sample_ready = 1 after release
- o_angle = 0x0000
- o_angle_valid = 0
- accumulator = 0
- bit index = 12
REQ-017 Reset asserted mid-SEARCH or in DONE SHALL discard the pending result; no o_angle_valid pulse SHALL follow release.

Structure
REQ-018 Package orpheus_pkg SHALL hold:
- SINE_FULL_SCALE = 4096
- QUARTER_TURN = 16'h2000
- ASIN_SAR_BITS = 13
- state enum asin_state_t {IDLE, SEARCH, DONE}
REQ-019 The block SHALL instantiate exactly one combinational orpheus_sine16, driven by the trial angle, as its only sub-module.
REQ-020 The critical path SHALL be one sine16 evaluation plus one 16-bit compare per cycle; there SHALL be no multi-cycle path constraints.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- i_sample = 4096 -> o_angle = 0x2000; i_sample = -4096 -> 0xE000; i_sample = -32768 -> 0xE000; each valid 1 cycle after the handshake.
- i_sample = 0 -> o_angle = 0x0000, valid 1 cycle after the handshake.
- i_sample = 2896 (sin 45 deg) -> o_angle in 0x0FFF..0x1001, valid exactly 14 cycles after the handshake; i_sample = -2896 -> the negation.
- Sweep a = 0..0x2000 step 0x40: feed sine16(a) -> sine16(o_angle) <= input < sine16(o_angle + 1), with |o_angle - a| <= 2.
- i_angle_ready held low 5 cycles in DONE -> o_angle stable, o_sample_ready = 0, and i_sample changes ignored; accept -> IDLE the next cycle.
- i_rst_n pulsed low at SEARCH cycle 6 -> outputs take reset values at once, no o_angle_valid after release, and a fresh sample of 2048 -> o_angle ~0x0AAB.
